// File: rtl/hex_keypad_entry.sv
// Hex keypad scanner with debounce and a 16-bit entry shift register.
// Columns are driven one at a time (active-low); rows are sampled through a
// two-flop synchronizer once per prescaler tick. A key is accepted after
// DEBOUNCE_CNT stable ticks, and must be released for DEBOUNCE_CNT ticks
// before scanning resumes. Accepted codes shift into the entry register.
module hex_keypad_entry #(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic       clear,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] S_hi,
    output logic [3:0] S_lo,
    output logic [3:0] R_hi,
    output logic [3:0] R_lo
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  DB       = 4'(DEBOUNCE_CNT);

    logic [3:0]  rs_meta;
    logic [3:0]  rs;
    logic [15:0] presc;
    logic        tick;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  stb_cnt;
    logic [3:0]  stb_nx;
    logic [3:0]  stb_inc;
    logic [3:0]  cols_nx;
    logic [1:0]  col_idx;
    logic [1:0]  col_nx;
    logic [1:0]  row_lat;
    logic [1:0]  row_nx;
    logic        accept;

    logic        single;
    logic [1:0]  row_idx;
    logic        all_high;

    logic [15:0] entry;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= rows;
            rs      <= rs_meta;
        end
    end

    // Free-running prescaler producing one scan tick every CLK_DIV cycles
    always_ff @(posedge clk_in) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    assign tick = (presc == DIV_LAST);

    // Classify the synchronized row pattern: exactly one low bit is a single key
    always_comb begin
        single   = 1'b0;
        row_idx  = 2'd0;
        all_high = (rs == 4'hF);
        case (rs)
            4'b1110: begin single = 1'b1; row_idx = 2'd0; end
            4'b1101: begin single = 1'b1; row_idx = 2'd1; end
            4'b1011: begin single = 1'b1; row_idx = 2'd2; end
            4'b0111: begin single = 1'b1; row_idx = 2'd3; end
            default: begin single = 1'b0; row_idx = 2'd0; end
        endcase
    end

    // Scan/debounce FSM next-state logic; everything advances only on a tick
    always_comb begin
        state_nx = state;
        stb_nx   = stb_cnt;
        cols_nx  = cols;
        col_nx   = col_idx;
        row_nx   = row_lat;
        accept   = 1'b0;
        stb_inc  = stb_cnt + 4'd1;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single) begin
                        row_nx = row_idx;
                        // A one-tick debounce accepts on the detecting tick itself
                        if (DB == 4'd1) begin
                            state_nx = HELD;
                            stb_nx   = '0;
                            accept   = 1'b1;
                        end else begin
                            state_nx = DEBOUNCE;
                            stb_nx   = 4'd1;
                        end
                    end else begin
                        cols_nx = {cols[2:0], cols[3]};
                        col_nx  = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (single && (row_idx == row_lat)) begin
                        if (stb_inc == DB) begin
                            state_nx = HELD;
                            stb_nx   = '0;
                            accept   = 1'b1;
                        end else begin
                            stb_nx = stb_inc;
                        end
                    end else begin
                        state_nx = SCAN;
                        stb_nx   = '0;
                    end
                end
                HELD: begin
                    if (all_high) begin
                        // The first released tick already counts toward release
                        if (DB == 4'd1) begin
                            state_nx = SCAN;
                            stb_nx   = '0;
                        end else begin
                            state_nx = RELEASE;
                            stb_nx   = 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (all_high) begin
                        if (stb_inc == DB) begin
                            state_nx = SCAN;
                            stb_nx   = '0;
                        end else begin
                            stb_nx = stb_inc;
                        end
                    end else begin
                        state_nx = HELD;
                        stb_nx   = '0;
                    end
                end
                default: begin
                    state_nx = SCAN;
                    stb_nx   = '0;
                end
            endcase
        end
    end

    // FSM state, column drive and latched row/column registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state   <= SCAN;
            stb_cnt <= '0;
            cols    <= 4'b1110;
            col_idx <= 2'd0;
            row_lat <= 2'd0;
        end else begin
            state   <= state_nx;
            stb_cnt <= stb_nx;
            cols    <= cols_nx;
            col_idx <= col_nx;
            row_lat <= row_nx;
        end
    end

    // Registered key strobe and code of the most recently accepted key
    always_ff @(posedge clk_in) begin
        if (reset) begin
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= {row_nx, col_idx};
            end
        end
    end

    // Entry shift register; clear has priority over a coincident key
    always_ff @(posedge clk_in) begin
        if (reset) begin
            entry <= '0;
        end else if (clear) begin
            entry <= '0;
        end else if (key_valid) begin
            entry <= {entry[11:0], key_code};
        end
    end

    assign S_hi = entry[15:12];
    assign S_lo = entry[11:8];
    assign R_hi = entry[7:4];
    assign R_lo = entry[3:0];

endmodule

// File: doc/hex_keypad_entry.md
HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

Interface
REQ-001 Parameter CLK_DIV, default 50000: clk_in cycles per scan tick, legal range 2..65535.
REQ-002 Parameter DEBOUNCE_CNT, default 4: consecutive stable ticks required for press or release, legal range 1..15.
REQ-003 Port clk_in, input, 1: sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port rows, input, 4: keypad row lines, active-low, pulled up externally, asynchronous to clk_in.
REQ-006 Port clear, input, 1: synchronous clear of the entry register.
REQ-007 Port cols, output, 4: keypad column drive, active-low, exactly one bit low at all times.
REQ-008 Port key_valid, output, 1: one-cycle pulse on each accepted key press.
REQ-009 Port key_code, output, 4: code of the last accepted key, row_idx*4 + col_idx.
REQ-010 Ports S_hi, S_lo, R_hi, R_lo, output, 4 each: entry register nibbles [15:12], [11:8], [7:4], [3:0].

Function
REQ-011 rows SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-012 Prescaler counts 0..CLK_DIV-1 and wraps; tick is high for one cycle when count = CLK_DIV-1.
REQ-013 A row pattern is "single" when exactly one bit of rs is 0; row_idx is that bit position.
REQ-014 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN, tick, rs single: latch row_idx, latch col_idx of the active column, stb_cnt<=1, go to DEBOUNCE; cols is not rotated.
REQ-016 SCAN, tick, rs not single (all high or multiple low): rotate cols 1110->1101->1011->0111->1110; col_idx follows.
REQ-017 DEBOUNCE, tick, rs single and equal to the latched row: stb_cnt++; when stb_cnt reaches DEBOUNCE_CNT, go to HELD and fire key_valid.
REQ-018 DEBOUNCE, tick, rs differs from the latched row: stb_cnt<=0, return to SCAN, and resume rotation on the next tick.
REQ-019 With DEBOUNCE_CNT=1, the detecting tick in SCAN SHALL accept the key directly.
REQ-020 key_valid SHALL be high for exactly one clk_in cycle, the cycle after the accepting tick.
REQ-021 key_code SHALL update on the same edge key_valid rises and hold between presses.
REQ-022 HELD, tick, rs all high: stb_cnt<=1, go to RELEASE. Any other rs keeps HELD.
REQ-023 HELD never produces a repeat key_valid, so there is no auto-repeat.
REQ-024 RELEASE, tick, rs all high: stb_cnt++; at DEBOUNCE_CNT, go to SCAN with stb_cnt<=0.
REQ-025 RELEASE, tick, rs not all high: return to HELD, stb_cnt<=0.
REQ-026 cols SHALL hold the pressed column throughout DEBOUNCE, HELD and RELEASE.
REQ-027 Entry register, 16 bits: on key_valid, entry <= {entry[11:0], key_code}; bits shift out of the top and are discarded.
REQ-028 clear=1 sets entry to 0; when clear and key_valid coincide, clear SHALL win and the key is dropped from entry, but key_code still updates.
REQ-029 All outputs SHALL be registered, with no combinational path from rows to any output.

Reset
REQ-030 reset=1 SHALL force, on the next edge: state=SCAN, cols=4'b1110, prescaler=0, stb_cnt=0, sync flops=4'hF, key_valid=0, key_code=0, entry=0.
REQ-031 reset SHALL override clear, tick and key acceptance in any state, including mid-debounce and HELD.
REQ-032 A key still held after reset releases SHALL be re-detected and accepted normally.

Verification (CLK_DIV=4, DEBOUNCE_CNT=3)
REQ-033 Press key row1/col2, held stable until accepted, then released -> one key_valid pulse, key_code=4'h6, entry=16'h0006, cols returns to rotating after 3 released ticks.
REQ-034 Press sequence 1,2,3,4,5 (codes) -> S_hi..R_lo = 2,3,4,5 and exactly 5 key_valid pulses.
REQ-035 Bounce: row0 low for 1 tick, high for 1 tick, then stable -> no pulse until 3 consecutive stable ticks, then exactly one pulse.
REQ-036 Two rows low in the same column -> no key_valid and cols keeps rotating.
REQ-037 Key held for 100 ticks -> a single key_valid. Assert clear while key_valid is high -> entry=0 and key_code updated.
REQ-038 Assert reset while in HELD -> cols=1110 and entry=0; the held key is re-accepted about 3 ticks after reset drops.
